// File: rtl/tia_beam_scheduler.sv
// Beam-timing controller for the TIA video path: walks the 456x262 beam, paces LCD pixel
// writes with a post-write gap, stalls the CPU for WSYNC and restarts the frame on VSYNC.
module tia_beam_scheduler #(
    parameter int unsigned H_TOTAL   = 456,
    parameter int unsigned H_VISIBLE = 320,
    parameter int unsigned V_TOTAL   = 262,
    parameter int unsigned V_VISIBLE = 240,
    parameter int unsigned V_TOP     = 24,
    parameter int unsigned V_BOT     = 226,
    parameter int unsigned FREE_X    = 319,
    parameter int unsigned PIX_GAP   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wsync_req,
    input  logic        vsync_req,
    input  logic        lcd_busy,
    output logic [10:0] hpos,
    output logic [9:0]  vpos,
    output logic        pix_valid,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_blank,
    output logic        reset_cursor,
    output logic        stall_cpu,
    output logic [7:0]  frame_count
);

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] H_FREE   = 11'(FREE_X);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]  V_TOPL   = 10'(V_TOP);
    localparam logic [9:0]  V_BOTL   = 10'(V_BOT);
    localparam logic [7:0]  GAP_LOAD = 8'(PIX_GAP - 1);

    typedef enum logic {RUN, GAP} state_e;

    state_e      state_q, state_d;
    logic [7:0]  gap_q, gap_d;
    logic [10:0] hpos_q, hpos_d;
    logic [9:0]  vpos_q, vpos_d;
    logic        pix_valid_q, pix_valid_d;
    logic [10:0] pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic        pix_blank_q, pix_blank_d;
    logic        reset_cursor_q, reset_cursor_d;
    logic        stall_q, stall_d;
    logic [7:0]  frame_q, frame_d;
    logic        step;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= RUN;
            gap_q          <= '0;
            hpos_q         <= '0;
            vpos_q         <= '0;
            pix_valid_q    <= 1'b0;
            pix_x_q        <= '0;
            pix_y_q        <= '0;
            pix_blank_q    <= 1'b0;
            reset_cursor_q <= 1'b0;
            stall_q        <= 1'b0;
            frame_q        <= '0;
        end else begin
            state_q        <= state_d;
            gap_q          <= gap_d;
            hpos_q         <= hpos_d;
            vpos_q         <= vpos_d;
            pix_valid_q    <= pix_valid_d;
            pix_x_q        <= pix_x_d;
            pix_y_q        <= pix_y_d;
            pix_blank_q    <= pix_blank_d;
            reset_cursor_q <= reset_cursor_d;
            stall_q        <= stall_d;
            frame_q        <= frame_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        gap_d          = gap_q;
        hpos_d         = hpos_q;
        vpos_d         = vpos_q;
        pix_valid_d    = 1'b0;
        pix_x_d        = pix_x_q;
        pix_y_d        = pix_y_q;
        pix_blank_d    = pix_blank_q;
        reset_cursor_d = 1'b0;
        stall_d        = stall_q;
        frame_d        = frame_q;
        step           = 1'b0;

        // VSYNC overrides everything, including a coincident WSYNC
        if (vsync_req) begin
            hpos_d         = '0;
            vpos_d         = '0;
            reset_cursor_d = 1'b1;
            stall_d        = 1'b0;
            frame_d        = frame_q + 8'd1;
            state_d        = RUN;
            gap_d          = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (!lcd_busy) begin
                        step = 1'b1;
                        if (hpos_q < H_LAST) begin
                            hpos_d = hpos_q + 11'd1;
                        end else begin
                            hpos_d = '0;
                            vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
                        end
                        if (hpos_q < H_VIS && vpos_q < V_VIS) begin
                            pix_valid_d = 1'b1;
                            pix_x_d     = hpos_q;
                            pix_y_d     = vpos_q;
                            pix_blank_d = (vpos_q < V_TOPL) || (vpos_q >= V_BOTL);
                            state_d     = GAP;
                            gap_d       = GAP_LOAD;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == 8'd0) begin
                        state_d = RUN;
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
                default: state_d = RUN;
            endcase

            // A new WSYNC beats a release landing on the same cycle
            if (wsync_req) begin
                stall_d = 1'b1;
            end else if (step && hpos_q == H_FREE) begin
                stall_d = 1'b0;
            end
        end
    end

    assign hpos         = hpos_q;
    assign vpos         = vpos_q;
    assign pix_valid    = pix_valid_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign pix_blank    = pix_blank_q;
    assign reset_cursor = reset_cursor_q;
    assign stall_cpu    = stall_q;
    assign frame_count  = frame_q;

endmodule

// File: tb/tb_tia_beam_scheduler.sv
// Bench for tia_beam_scheduler: table vectors, directed corner sequences and random stimulus,
// checked against a linear-position beam model on a full-size and a shrunken instance.
module tb_tia_beam_scheduler;

    typedef struct {
        int ht, hv, vt, vv, vtop, vbot, freex, gap;
    } cfg_t;

    typedef struct {
        int pos;
        int gapLeft;
        bit stall;
        int frame;
        bit pv;
        int px;
        int py;
        bit blank;
        bit rc;
    } beam_t;

    typedef struct {
        bit wsync, vsync, busy;
        int expH, expV, expPv, expPx, expBlank, expStall, expRc, expFrame;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, wsyncReq, vsyncReq, lcdBusy;

    logic [10:0] aHpos, aPixX, bHpos, bPixX;
    logic [9:0]  aVpos, aPixY, bVpos, bPixY;
    logic        aPv, aBlank, aRc, aStall, bPv, bBlank, bRc, bStall;
    logic [7:0]  aFrame, bFrame;

    tia_beam_scheduler dutA (
        .clk_i(clk), .rst_i(rst), .wsync_req(wsyncReq), .vsync_req(vsyncReq), .lcd_busy(lcdBusy),
        .hpos(aHpos), .vpos(aVpos), .pix_valid(aPv), .pix_x(aPixX), .pix_y(aPixY),
        .pix_blank(aBlank), .reset_cursor(aRc), .stall_cpu(aStall), .frame_count(aFrame)
    );

    tia_beam_scheduler #(
        .H_TOTAL(20), .H_VISIBLE(8), .V_TOTAL(12), .V_VISIBLE(10),
        .V_TOP(2), .V_BOT(8), .FREE_X(6), .PIX_GAP(2)
    ) dutB (
        .clk_i(clk), .rst_i(rst), .wsync_req(wsyncReq), .vsync_req(vsyncReq), .lcd_busy(lcdBusy),
        .hpos(bHpos), .vpos(bVpos), .pix_valid(bPv), .pix_x(bPixX), .pix_y(bPixY),
        .pix_blank(bBlank), .reset_cursor(bRc), .stall_cpu(bStall), .frame_count(bFrame)
    );

    cfg_t  cfgA, cfgB;
    beam_t mA, mB;
    int    checks = 0;
    int    errors = 0;
    int    cycleNo = 0;
    vec_t  vecs[13];

    function automatic beam_t modelReset();
        beam_t m;
        m.pos = 0; m.gapLeft = 0; m.stall = 0; m.frame = 0;
        m.pv = 0; m.px = 0; m.py = 0; m.blank = 0; m.rc = 0;
        return m;
    endfunction

    // gapLeft counts idle cycles still owed after a pixel write; the beam is a single index.
    function automatic beam_t modelStep(beam_t m, cfg_t c, bit w, bit vs, bit b);
        beam_t n;
        int x, y;
        bit stepped;
        n = m;
        n.pv = 0;
        n.rc = 0;
        if (vs) begin
            n.pos = 0; n.gapLeft = 0; n.stall = 0; n.rc = 1;
            n.frame = (m.frame + 1) % 256;
            return n;
        end
        x = m.pos % c.ht;
        y = m.pos / c.ht;
        stepped = (m.gapLeft == 0) && !b;
        if (m.gapLeft > 0) begin
            n.gapLeft = m.gapLeft - 1;
        end else if (stepped) begin
            n.pos = (m.pos + 1) % (c.ht * c.vt);
            if (x < c.hv && y < c.vv) begin
                n.pv = 1; n.px = x; n.py = y;
                n.blank = (y < c.vtop) || (y >= c.vbot);
                n.gapLeft = c.gap;
            end
        end
        if (w) n.stall = 1;
        else if (stepped && x == c.freex) n.stall = 0;
        return n;
    endfunction

    function automatic vec_t mkVec(bit w, bit vs, bit b, int h, int v, int pv, int px,
                                   int bl, int st, int rc, int fr);
        vec_t r;
        r.wsync = w; r.vsync = vs; r.busy = b;
        r.expH = h; r.expV = v; r.expPv = pv; r.expPx = px;
        r.expBlank = bl; r.expStall = st; r.expRc = rc; r.expFrame = fr;
        return r;
    endfunction

    task automatic checkVal(string name, int actual, int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d actual %0d required %0d", name, cycleNo, actual, required);
        end
    endtask

    task automatic compareBeam(string tag, beam_t m, cfg_t c, logic [10:0] h, logic [9:0] v,
                               logic pv, logic [10:0] px, logic [9:0] py, logic bl, logic rc,
                               logic st, logic [7:0] fc);
        int eh, ev;
        bit ok;
        eh = m.pos % c.ht;
        ev = m.pos / c.ht;
        ok = (int'(h) == eh) && (int'(v) == ev) && (pv == m.pv) && (int'(px) == m.px) &&
             (int'(py) == m.py) && (bl == m.blank) && (rc == m.rc) && (st == m.stall) &&
             (int'(fc) == m.frame);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d actual h=%0d v=%0d pv=%0d px=%0d py=%0d bl=%0d rc=%0d st=%0d fc=%0d required h=%0d v=%0d pv=%0d px=%0d py=%0d bl=%0d rc=%0d st=%0d fc=%0d",
                     tag, cycleNo, h, v, pv, px, py, bl, rc, st, fc,
                     eh, ev, m.pv, m.px, m.py, m.blank, m.rc, m.stall, m.frame);
        end
    endtask

    task automatic checkOutput();
        compareBeam("modelA", mA, cfgA, aHpos, aVpos, aPv, aPixX, aPixY, aBlank, aRc, aStall, aFrame);
        compareBeam("modelB", mB, cfgB, bHpos, bVpos, bPv, bPixX, bPixY, bBlank, bRc, bStall, bFrame);
    endtask

    // Called at posedge+1; drives inputs for the next edge, advances both models, then checks.
    task automatic applyStimulus(bit w, bit vs, bit b);
        wsyncReq = w;
        vsyncReq = vs;
        lcdBusy  = b;
        @(posedge clk);
        mA = modelStep(mA, cfgA, w, vs, b);
        mB = modelStep(mB, cfgB, w, vs, b);
        #1;
        cycleNo++;
        checkOutput();
    endtask

    initial begin
        beam_t tmp;
        int savedH, savedV, n;
        bit done;

        cfgA = '{ht: 456, hv: 320, vt: 262, vv: 240, vtop: 24, vbot: 226, freex: 319, gap: 8};
        cfgB = '{ht: 20, hv: 8, vt: 12, vv: 10, vtop: 2, vbot: 8, freex: 6, gap: 2};
        mA = modelReset();
        mB = modelReset();

        vecs[0]  = mkVec(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        vecs[1]  = mkVec(1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        vecs[2]  = mkVec(0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 3; i <= 8; i++) vecs[i] = mkVec(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        vecs[9]  = mkVec(0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0);
        vecs[10] = mkVec(0, 0, 0, 2, 0, 1, 1, 1, 1, 0, 0);
        vecs[11] = mkVec(1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1);
        vecs[12] = mkVec(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1);

        rst = 1'b1; wsyncReq = 1'b0; vsyncReq = 1'b0; lcdBusy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput();
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].wsync, vecs[i].vsync, vecs[i].busy);
            checkVal($sformatf("vec%0d.hpos", i), aHpos, vecs[i].expH);
            checkVal($sformatf("vec%0d.vpos", i), aVpos, vecs[i].expV);
            checkVal($sformatf("vec%0d.pixValid", i), aPv, vecs[i].expPv);
            checkVal($sformatf("vec%0d.pixX", i), aPixX, vecs[i].expPx);
            checkVal($sformatf("vec%0d.pixBlank", i), aBlank, vecs[i].expBlank);
            checkVal($sformatf("vec%0d.stall", i), aStall, vecs[i].expStall);
            checkVal($sformatf("vec%0d.resetCursor", i), aRc, vecs[i].expRc);
            checkVal($sformatf("vec%0d.frame", i), aFrame, vecs[i].expFrame);
        end

        // full line 0 on the large instance, then wrap into line 1
        applyStimulus(0, 1, 0);
        done = 0;
        for (n = 1; n <= 3100; n++) begin
            applyStimulus(0, 0, 0);
            if (aVpos == 10'd1) begin
                done = 1;
                break;
            end
        end
        checkVal("lineWrapReached", int'(done), 1);
        checkVal("lineWrapCycles", n, 3016);
        checkVal("lineWrapHpos", aHpos, 0);

        // frame_count wrap with a VSYNC landing inside a pixel gap
        n = 0;
        while (mA.frame != 255 && n < 300) begin
            applyStimulus(0, 1, 0);
            n++;
        end
        checkVal("frameReach255", aFrame, 255);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        checkVal("preVsyncStall", aStall, 1);
        applyStimulus(1, 1, 0);
        checkVal("vsyncHpos", aHpos, 0);
        checkVal("vsyncVpos", aVpos, 0);
        checkVal("vsyncResetCursor", aRc, 1);
        checkVal("vsyncStall", aStall, 0);
        checkVal("vsyncFrameWrap", aFrame, 0);
        checkVal("vsyncPixValid", aPv, 0);
        applyStimulus(0, 0, 0);
        checkVal("resetCursorPulse", aRc, 0);

        // WSYNC on the small instance: set wins over a same-cycle release, then a clean release
        applyStimulus(0, 1, 0);
        applyStimulus(1, 0, 0);
        checkVal("wsyncSet", bStall, 1);
        done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            tmp = modelStep(mB, cfgB, 0, 0, 0);
            if (mB.stall && !tmp.stall) begin
                applyStimulus(1, 0, 0);
                checkVal("wsyncSetWins", bStall, 1);
                done = 1;
            end else begin
                applyStimulus(0, 0, 0);
            end
        end
        checkVal("wsyncSetWinsReached", int'(done), 1);
        done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            tmp = modelStep(mB, cfgB, 0, 0, 0);
            applyStimulus(0, 0, 0);
            if (!tmp.stall) begin
                checkVal("wsyncRelease", bStall, 0);
                done = 1;
            end
        end
        checkVal("wsyncReleaseReached", int'(done), 1);

        // lcd_busy in RUN on the large instance freezes the beam
        applyStimulus(0, 1, 0);
        repeat (3) applyStimulus(0, 0, 0);
        for (int k = 0; k < 20 && mA.gapLeft != 0; k++) applyStimulus(0, 0, 0);
        savedH = mA.pos % cfgA.ht;
        savedV = mA.pos / cfgA.ht;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 0, 1);
            checkVal("busyHoldH", aHpos, savedH);
            checkVal("busyHoldV", aVpos, savedV);
            checkVal("busyNoPixel", aPv, 0);
        end
        applyStimulus(0, 0, 0);
        checkVal("busyReleasePixValid", aPv, 1);
        checkVal("busyReleasePixX", aPixX, savedH);

        // random traffic against the model
        for (int k = 0; k < 4000; k++) begin
            applyStimulus(($urandom % 25) == 0, ($urandom % 600) == 0, ($urandom % 5) == 0);
        end

        // asynchronous reset mid-line with the CPU stalled
        applyStimulus(1, 0, 0);
        repeat (5) applyStimulus(0, 0, 0);
        @(posedge clk);
        mA = modelStep(mA, cfgA, 0, 0, 0);
        mB = modelStep(mB, cfgB, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        cycleNo++;
        checkVal("asyncResetHpos", aHpos, 0);
        checkVal("asyncResetVpos", aVpos, 0);
        checkVal("asyncResetStall", aStall, 0);
        checkVal("asyncResetPixValid", aPv, 0);
        checkVal("asyncResetSmallHpos", bHpos, 0);
        mA = modelReset();
        mB = modelReset();
        @(posedge clk);
        #1;
        checkOutput();
        rst = 1'b0;
        applyStimulus(0, 0, 0);
        checkVal("postResetPixValid", aPv, 1);
        checkVal("postResetPixX", aPixX, 0);
        checkVal("postResetPixY", aPixY, 0);
        checkVal("postResetPixBlank", aBlank, 1);
        repeat (50) applyStimulus(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
